adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin arbiter that time-shares one signed `adder` instance among `NUM_REQ` requesters (e.g. PE partial-sum lanes) over valid/ready handshakes. Each accepted operand pair is summed, scaled and captured in a single output register tagged with the requester index. The output register can accept a new operand pair in the same cycle it drains, so throughput is one sum per cycle. It sits between the PE-array partial-sum ports and the accumulator/writeback stage.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2
- `A_WIDTH`, 16: width of operand a, signed
- `B_WIDTH`, 16: width of operand b, signed
- `OUT_WIDTH`, `$max(A_WIDTH,B_WIDTH)+1`: result width
- `OUT_SCALE`, 0: arithmetic right shift applied to the sum
- `ID_WIDTH`, `$clog2(NUM_REQ)`: derived; do not override

- `clk` in 1: single clock, rising edge
- `rst_n_in` in 1: reset, synchronous, active-low
- `req_valid` in `[NUM_REQ]`: requester i presents operands
- `req_ready` out `[NUM_REQ]`: requester i is granted this cycle
- `req_a` in `[NUM_REQ][A_WIDTH]` signed: operand a per requester
- `req_b` in `[NUM_REQ][B_WIDTH]` signed: operand b per requester
- `rsp_valid` out 1: result register holds a valid sum
- `rsp_ready` in 1: downstream consumes the result
- `rsp_sum` out `OUT_WIDTH` signed: scaled sum
- `rsp_id` out `ID_WIDTH`: index of the originating requester

## Operation
- Output FSM states: EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
- Accept condition: `can_accept = EMPTY | (FULL & rsp_ready)`.
- Grant is combinational. Scan starts at `rr_ptr` and wraps modulo `NUM_REQ`. The first i with `req_valid[i]` wins, but only if `can_accept`.
- At most one `req_ready` bit is high, and it is high only for a requester whose `req_valid` is also high.
- A transfer on requester i occurs when `req_valid[i] & req_ready[i]`. On that transfer:
  - `rsp_sum` ← adder result
  - `rsp_id` ← i
  - state ← FULL
  - `rr_ptr` ← (i+1) mod `NUM_REQ`
- When `FULL & rsp_ready` and no transfer occurs: state ← EMPTY. `rsp_sum`/`rsp_id` keep their last values.
- When `FULL & !rsp_ready`: `rsp_sum`, `rsp_id` and `rsp_valid` are held stable, and all `req_ready` bits are 0.
- `rr_ptr` is unchanged in any cycle without a transfer.
- Requester rule: once `req_valid[i]` is asserted, it stays high and `req_a`/`req_b` stay stable until the transfer. The block does not check this.
- Arithmetic is done in the `adder` sub-module:
  - Sign-extend both operands to `A_WIDTH+B_WIDTH` bits and add.
  - Arithmetic shift right by `OUT_SCALE`.
  - Truncate to the low `OUT_WIDTH` bits. There is no saturation, and wrap-around is the required behaviour.
- Fairness: with all requesters continuously valid and `rsp_ready`=1, grants follow the sequence ptr, ptr+1, … mod `NUM_REQ`. No requester waits more than `NUM_REQ` transfers.

## Timing
- Latency: operands accepted at rising edge k appear on `rsp_sum`/`rsp_id`, with `rsp_valid`=1, from edge k onward, i.e. visible in cycle k+1.
- Throughput: one transfer per cycle while `rsp_ready`=1.
- `req_ready` depends combinationally on `req_valid`, `rsp_ready` and state. There is no combinational path from `req_a`/`req_b` to any output except through the register.
- Reset values, applied at the first rising edge with `rst_n_in`=0:
  - `rsp_valid` = 0
  - `rsp_sum` = 0
  - `rsp_id` = 0
  - `rr_ptr` = 0
  - state = EMPTY
- While `rst_n_in`=0, `req_ready` is forced to all zeros. No transfer is counted.
- Reset mid-operation: a pending FULL result is discarded without handshake.
- Simultaneous drain and accept (`FULL & rsp_ready` with a valid request): the new result replaces the old one in the same edge, and state stays FULL.

## Structure
- Shared package `adder_arbiter_pkg` holds:
  - `NUM_REQ_DEFAULT` localparam
  - `rsp_state_e` typedef (EMPTY, FULL)
  - a `rr_pick` function returning the one-hot grant from valid bits and `rr_ptr`
- One sub-module: `adder`, instantiated once. Its `a`/`b` inputs are muxed by the one-hot grant, and its parameters are forwarded unchanged.

## Test plan
- Reset: hold `rst_n_in`=0 for 3 cycles with all `req_valid`=1 → `req_ready`=0000, `rsp_valid`=0, `rsp_sum`=0, `rsp_id`=0.
- Single request: req 2 with a=100, b=−30, `OUT_SCALE`=0, `rsp_ready`=1 → `req_ready`=0100 in that cycle; next cycle `rsp_sum`=70, `rsp_id`=2, `rsp_valid`=1.
- Round-robin: all 4 valid continuously, `rsp_ready`=1, 8 cycles after reset → `rsp_id` sequence 0,1,2,3,0,1,2,3, with one result per cycle.
- Backpressure: `rsp_ready`=0 for 5 cycles while FULL with req 1 valid → `req_ready`=0000 and `rsp_sum`/`rsp_id` stable; on `rsp_ready`=1, req 1 is granted in that same cycle and the new result appears the next cycle.
- Scale and wrap: `OUT_SCALE`=1, a=32767, b=32767 → `rsp_sum`=32767. Separately, `OUT_SCALE`=0 with `OUT_WIDTH`=8, a=100, b=100 → `rsp_sum`=−56.
- Reset mid-operation: FULL with `rsp_ready`=0, then `rst_n_in`=0 for 1 cycle → `rsp_valid`=0 and `rr_ptr`=0, so the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared types and the round-robin pick used by the adder arbiter.
package adder_arbiter_pkg;

    localparam int NUM_REQ_DEFAULT = 4;

    // Widest requester vector the pick function handles; NUM_REQ must stay below this.
    localparam int RR_MAX    = 32;
    localparam int RR_IDX_W  = 5;
    localparam int IDX_EXT_W = RR_IDX_W + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

    // One-hot grant: first valid lane found scanning upward from ptr, wrapping at n.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0]    valid,
        input logic [RR_IDX_W-1:0]  ptr,
        input logic [IDX_EXT_W-1:0] n
    );
        logic [RR_MAX-1:0]    grant;
        logic                 found;
        logic [IDX_EXT_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < RR_MAX; k++) begin
            idx = {1'b0, ptr} + IDX_EXT_W'(k);
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((IDX_EXT_W'(k) < n) && !found && valid[idx[RR_IDX_W-1:0]]) begin
                grant[idx[RR_IDX_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/adder_arbiter_adder.sv
// Signed adder: sign-extend, add, arithmetic shift, wrap to the output width.
module adder #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1,
    parameter int OUT_SCALE = 0
) (
    input  logic signed [A_WIDTH-1:0]   a,
    input  logic signed [B_WIDTH-1:0]   b,
    output logic signed [OUT_WIDTH-1:0] sum
);

    localparam int SUM_W = A_WIDTH + B_WIDTH;

    // Scale down and keep the low bits; overflow wraps, no saturation.
    function automatic logic signed [OUT_WIDTH-1:0] scale_wrap(
        input logic signed [SUM_W-1:0] full
    );
        return OUT_WIDTH'(full >>> OUT_SCALE);
    endfunction

    logic signed [SUM_W-1:0] full_sum;

    assign full_sum = SUM_W'(a) + SUM_W'(b);
    assign sum      = scale_wrap(full_sum);

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one signed adder among NUM_REQ requesters,
// with a single skid-free output register that can drain and refill each cycle.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEFAULT,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1,
    parameter int OUT_SCALE = 0,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n_in,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic signed [A_WIDTH-1:0]   req_a [NUM_REQ],
    input  logic signed [B_WIDTH-1:0]   req_b [NUM_REQ],
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic signed [OUT_WIDTH-1:0] rsp_sum,
    output logic [ID_WIDTH-1:0]         rsp_id
);

    rsp_state_e                 state;
    logic [ID_WIDTH-1:0]        rr_ptr;
    logic                       can_accept;
    logic [RR_MAX-1:0]          pick_p0;
    logic [NUM_REQ-1:0]         grant_p0;
    logic                       xfer_p0;
    logic [ID_WIDTH-1:0]        grant_id_p0;
    logic [ID_WIDTH-1:0]        next_ptr;
    logic signed [A_WIDTH-1:0]  a_sel_p0;
    logic signed [B_WIDTH-1:0]  b_sel_p0;
    logic signed [OUT_WIDTH-1:0] sum_p0;
    logic signed [OUT_WIDTH-1:0] sum_p1;
    logic [ID_WIDTH-1:0]        id_p1;
    logic                       vld_p1;

    // ---- stage p0: grant selection and operand mux ----
    assign can_accept = (state == EMPTY) || rsp_ready;
    assign pick_p0    = rr_pick(RR_MAX'(req_valid), RR_IDX_W'(rr_ptr), IDX_EXT_W'(NUM_REQ));

    // Lanes above NUM_REQ are never valid, so the upper pick bits are always zero;
    // gating on them leaves behaviour unchanged and keeps the whole pick consumed.
    assign grant_p0  = (rst_n_in && can_accept && !(|pick_p0[RR_MAX-1:NUM_REQ]))
                       ? pick_p0[NUM_REQ-1:0] : '0;
    assign req_ready = grant_p0;
    assign xfer_p0   = |grant_p0;

    // Encode the one-hot grant and steer the winning operands into the adder.
    always_comb begin
        grant_id_p0 = '0;
        a_sel_p0    = '0;
        b_sel_p0    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_p0[i]) begin
                grant_id_p0 = ID_WIDTH'(i);
                a_sel_p0    = req_a[i];
                b_sel_p0    = req_b[i];
            end
        end
    end

    assign next_ptr = (grant_id_p0 == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id_p0 + 1'b1;

    adder #(
        .A_WIDTH   (A_WIDTH),
        .B_WIDTH   (B_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_SCALE (OUT_SCALE)
    ) u_adder (
        .a   (a_sel_p0),
        .b   (b_sel_p0),
        .sum (sum_p0)
    );

    // ---- stage p1: result register ----
    // Output FSM: a transfer loads the result (even while draining), a drain alone empties.
    always_ff @(posedge clk) begin
        if (!rst_n_in) begin
            state  <= EMPTY;
            sum_p1 <= '0;
            id_p1  <= '0;
            rr_ptr <= '0;
        end else if (xfer_p0) begin
            state  <= FULL;
            sum_p1 <= sum_p0;
            id_p1  <= grant_id_p0;
            rr_ptr <= next_ptr;
        end else if ((state == FULL) && rsp_ready) begin
            state  <= EMPTY;
        end
    end

    assign vld_p1    = (state == FULL);
    assign rsp_valid = vld_p1;
    assign rsp_sum   = sum_p1;
    assign rsp_id    = id_p1;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: three DUT builds (default, scaled, narrow)
// share stimulus and are checked every cycle against a behavioural model.
module tb_adder_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n_in;
    logic [N-1:0]        req_valid;
    logic signed [15:0]  req_a [N];
    logic signed [15:0]  req_b [N];
    logic                rsp_ready;

    logic [N-1:0]        rdy0, rdy1, rdy2;
    logic                v0, v1, v2;
    logic signed [16:0]  s0, s1;
    logic signed [7:0]   s2;
    logic [1:0]          id0, id1, id2;

    adder_arbiter dut (
        .clk(clk), .rst_n_in(rst_n_in), .req_valid(req_valid), .req_ready(rdy0),
        .req_a(req_a), .req_b(req_b), .rsp_valid(v0), .rsp_ready(rsp_ready),
        .rsp_sum(s0), .rsp_id(id0)
    );

    adder_arbiter #(.OUT_SCALE(1)) dut_s (
        .clk(clk), .rst_n_in(rst_n_in), .req_valid(req_valid), .req_ready(rdy1),
        .req_a(req_a), .req_b(req_b), .rsp_valid(v1), .rsp_ready(rsp_ready),
        .rsp_sum(s1), .rsp_id(id1)
    );

    adder_arbiter #(.OUT_WIDTH(8)) dut_w (
        .clk(clk), .rst_n_in(rst_n_in), .req_valid(req_valid), .req_ready(rdy2),
        .req_a(req_a), .req_b(req_b), .rsp_valid(v2), .rsp_ready(rsp_ready),
        .rsp_sum(s2), .rsp_id(id2)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_ptr;
    bit     m_full;
    longint m_sum [3];
    int     m_id;
    bit     m_ok = 1'b0;

    function automatic longint wrap_sum(input longint a, input longint b,
                                        input int scale, input int w);
        longint s;
        longint mask;
        s    = (a + b) >>> scale;
        mask = (longint'(1) << w) - 1;
        s    = s & mask;
        if (s >= (longint'(1) << (w - 1))) s = s - (longint'(1) << w);
        return s;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        int idx;
        g = '0;
        if (!rst_n_in || (m_full && !rsp_ready)) return g;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // Inputs are stable from posedge+1 to the next posedge, so the negedge sees
    // exactly what the next edge will act on: compare, then advance the model.
    always @(negedge clk) begin
        logic [N-1:0] g;
        g = exp_grant();
        if (m_ok) begin
            chk("req_ready", rdy0, g);
            chk("req_ready_scaled", rdy1, g);
            chk("req_ready_narrow", rdy2, g);
            chk("rsp_valid", v0, m_full);
            chk("rsp_valid_scaled", v1, m_full);
            chk("rsp_valid_narrow", v2, m_full);
            chk("rsp_id", id0, m_id);
            chk("rsp_id_scaled", id1, m_id);
            chk("rsp_id_narrow", id2, m_id);
            chk("rsp_sum", s0, m_sum[0]);
            chk("rsp_sum_scaled", s1, m_sum[1]);
            chk("rsp_sum_narrow", s2, m_sum[2]);
        end
        if (!rst_n_in) begin
            m_ok   = 1'b1;
            m_full = 1'b0;
            m_ptr  = 0;
            m_id   = 0;
            m_sum  = '{0, 0, 0};
        end else if (m_ok) begin
            if (g != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (g[i]) begin
                        m_sum[0] = wrap_sum(req_a[i], req_b[i], 0, 17);
                        m_sum[1] = wrap_sum(req_a[i], req_b[i], 1, 17);
                        m_sum[2] = wrap_sum(req_a[i], req_b[i], 0, 8);
                        m_id     = i;
                        m_ptr    = (i + 1) % N;
                    end
                end
                m_full = 1'b1;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n_in  = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_a[i] = '0;
            req_b[i] = '0;
        end

        // Reset with every requester asking.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_req_ready", rdy0, 0);
            chk("rst_rsp_valid", v0, 0);
            chk("rst_rsp_sum", s0, 0);
            chk("rst_rsp_id", id0, 0);
        end
        rst_n_in  = 1'b1;
        req_valid = '0;
        tick();

        // Single request on lane 2.
        req_valid = 4'b0100;
        req_a[2]  = 100;
        req_b[2]  = -30;
        #1;
        chk("single_grant", rdy0, 4'b0100);
        tick();
        req_valid = '0;
        chk("single_sum", s0, 70);
        chk("single_id", id0, 2);
        chk("single_valid", v0, 1);
        tick();
        chk("single_drained", v0, 0);

        // Round-robin from a fresh pointer.
        rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_a[i] = 16'(1000 * i + 7);
            req_b[i] = 16'(-3 * i);
        end
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("rr_id", id0, c % 4);
            chk("rr_valid", v0, 1);
            chk("rr_sum", s0, 1000 * (c % 4) + 7 - 3 * (c % 4));
        end

        // Backpressure while holding lane 3's result (3007 - 9 = 2998).
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_no_grant", rdy0, 0);
            tick();
            chk("bp_hold_id", id0, 3);
            chk("bp_hold_sum", s0, 2998);
            chk("bp_hold_valid", v0, 1);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", rdy0, 4'b0010);
        tick();
        req_valid = '0;
        chk("bp_new_id", id0, 1);
        chk("bp_new_sum", s0, 1004);
        tick();

        // Scaling and wrap-around on lane 0.
        req_valid = 4'b0001;
        req_a[0]  = 32767;
        req_b[0]  = 32767;
        tick();
        chk("scale_sum", s1, 32767);
        chk("full_width_sum", s0, 65534);
        req_a[0] = 100;
        req_b[0] = 100;
        tick();
        chk("wrap_sum", s2, -56);
        req_a[0] = -32768;
        req_b[0] = -32768;
        tick();
        chk("neg_sum", s0, -65536);
        chk("neg_scale_sum", s1, -32768);
        chk("neg_wrap_sum", s2, 0);
        req_valid = '0;
        tick();

        // Reset while a stalled result is held.
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        req_a[3]  = -5;
        req_b[3]  = 2;
        tick();
        chk("mid_full_id", id0, 3);
        chk("mid_full_sum", s0, -3);
        tick();
        chk("mid_stall_valid", v0, 1);
        rst_n_in = 1'b0;
        #1;
        chk("mid_rst_ready", rdy0, 0);
        tick();
        chk("mid_rst_valid", v0, 0);
        chk("mid_rst_id", id0, 0);
        chk("mid_rst_sum", s0, 0);
        rst_n_in  = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0110;
        req_a[1]  = -7;
        req_b[1]  = -8;
        #1;
        chk("mid_rst_grant", rdy0, 4'b0010);
        tick();
        chk("mid_after_id", id0, 1);
        chk("mid_after_sum", s0, -15);
        req_valid = '0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
